// File: rtl/slc3_user_input.sv
// slc3_user_input
// ---------------------------------------------------------------------------
// Front end for the SLC-3 push-buttons and slide switches.
//   Run / Continue : raw active-low buttons. Each is synchronized with two
//                    flops and then debounced. Outputs are the debounced
//                    active-high levels plus a one-cycle press strobe.
//   SW             : raw switches. Synchronized with two flops, not debounced.
//
// Ports
//   Clk             system clock, rising edge
//   Reset_n         asynchronous active-low reset
//   Run, Continue   raw buttons, active-low, asynchronous to Clk
//   SW              raw switch bus
//   Run_level       debounced Run, 1 = held
//   Continue_level  debounced Continue, 1 = held
//   Run_pulse       one-cycle strobe on a debounced Run press
//   Continue_pulse  one-cycle strobe on a debounced Continue press
//   Soft_reset      high while both debounced levels are high
//   SW_sync         synchronized switch bus
// ---------------------------------------------------------------------------
module slc3_user_input #(
  parameter int DEBOUNCE_CYCLES = 2,   // 1..255
  parameter int SW_WIDTH        = 10
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Run,
  input  logic                Continue,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                Run_level,
  output logic                Continue_level,
  output logic                Run_pulse,
  output logic                Continue_pulse,
  output logic                Soft_reset,
  output logic [SW_WIDTH-1:0] SW_sync
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is Run, bit 1 is Continue throughout.
  logic [1:0]          btn_s1_q, btn_s2_q;
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic [7:0]          run_cnt_q, run_cnt_d;
  logic [7:0]          cont_cnt_q, cont_cnt_d;
  logic [1:0]          lvl_q, lvl_d;
  logic [1:0]          pulse_q, pulse_d;
  logic                soft_q, soft_d;

  // One debounce step: returns {next_level, next_count}.
  function automatic logic [8:0] db_step(input logic pressed,
                                         input logic level,
                                         input logic [7:0] cnt);
    logic [8:0] r;
    r = {level, 8'd0};
    if (pressed != level) begin
      if (cnt == CNT_MAX) r = {~level, 8'd0};
      else                r = {level, cnt + 8'd1};
    end
    return r;
  endfunction

  always_comb begin
    {lvl_d[0], run_cnt_d}  = db_step(~btn_s2_q[0], lvl_q[0], run_cnt_q);
    {lvl_d[1], cont_cnt_d} = db_step(~btn_s2_q[1], lvl_q[1], cont_cnt_q);
    // A press strobe fires in the cycle the level first reads 1, unless the
    // other button's level is also 1 in that cycle (held or rising together).
    pulse_d[0] = lvl_d[0] & ~lvl_q[0] & ~lvl_d[1];
    pulse_d[1] = lvl_d[1] & ~lvl_q[1] & ~lvl_d[0];
    // Registered so Soft_reset tracks the levels with no combinational glitch.
    soft_d     = lvl_d[0] & lvl_d[1];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      btn_s1_q   <= 2'b11;
      btn_s2_q   <= 2'b11;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      run_cnt_q  <= 8'd0;
      cont_cnt_q <= 8'd0;
      lvl_q      <= 2'b00;
      pulse_q    <= 2'b00;
      soft_q     <= 1'b0;
    end else begin
      btn_s1_q   <= {Continue, Run};
      btn_s2_q   <= btn_s1_q;
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      run_cnt_q  <= run_cnt_d;
      cont_cnt_q <= cont_cnt_d;
      lvl_q      <= lvl_d;
      pulse_q    <= pulse_d;
      soft_q     <= soft_d;
    end
  end

  assign Run_level      = lvl_q[0];
  assign Continue_level = lvl_q[1];
  assign Run_pulse      = pulse_q[0];
  assign Continue_pulse = pulse_q[1];
  assign Soft_reset     = soft_q;
  assign SW_sync        = sw_s2_q;

endmodule

// File: tb/tb_slc3_user_input.sv
// Bench for slc3_user_input. Stimulus pushes the expected output vector and
// the edge at which it must appear; the monitor compares every time the
// DUT's outputs change.
module tb_slc3_user_input;

  localparam int DB  = 2;
  localparam int LAT = DB + 2;   // drive-to-level edges (drive between edges)

  logic       Clk, Reset_n, Run, Continue;
  logic [9:0] SW;
  logic       Run_level, Continue_level, Run_pulse, Continue_pulse, Soft_reset;
  logic [9:0] SW_sync;

  slc3_user_input #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .SW(SW),
    .Run_level(Run_level), .Continue_level(Continue_level),
    .Run_pulse(Run_pulse), .Continue_pulse(Continue_pulse),
    .Soft_reset(Soft_reset), .SW_sync(SW_sync)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(posedge Clk) edge_n++;

  typedef struct {
    int          cyc;
    logic [14:0] vec;  // {RL, CL, RP, CP, SR, SW_sync}
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_sw = '0;
  logic [14:0] prev_v = '0;

  function automatic logic [14:0] outs();
    return {Run_level, Continue_level, Run_pulse, Continue_pulse, Soft_reset, SW_sync};
  endfunction

  task automatic expect_at(input int cyc, input logic rl, input logic cl,
                           input logic rp, input logic cp, input logic sr);
    exp_t e;
    e.cyc = cyc;
    e.vec = {rl, cl, rp, cp, sr, exp_sw};
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Monitor: reacts to any output change and matches it against the queue.
  always @(posedge Clk) begin
    logic [14:0] cur_v;
    exp_t e;
    #1;
    cur_v = outs();
    while (sb.size() > 0 && sb[0].cyc < edge_n) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event edge=%0d got=%h expected=%h at edge %0d",
               edge_n, cur_v, e.vec, e.cyc);
    end
    if (cur_v !== prev_v) begin
      checks++;
      if (sb.size() == 0 || sb[0].cyc != edge_n) begin
        errors++;
        $display("FAIL unexpected_change edge=%0d got=%h was=%h", edge_n, cur_v, prev_v);
      end else begin
        e = sb.pop_front();
        if (e.vec !== cur_v) begin
          errors++;
          $display("FAIL output_vector edge=%0d got=%h expected=%h", edge_n, cur_v, e.vec);
        end
      end
      prev_v = cur_v;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog_timeout edge=%0d", edge_n);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int t, r;
    logic [9:0] sw_vals [3];
    sw_vals[0] = 10'h00B; sw_vals[1] = 10'h00A; sw_vals[2] = 10'h3FF;

    Run = 1'b1; Continue = 1'b1; SW = '0; Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got=%h expected=%h", outs(), 15'd0);
    end
    wait_neg(2);
    Reset_n = 1'b1;
    wait_neg(3);

    // Single Run press, held 10 cycles.
    t = edge_n; Run = 1'b0;
    expect_at(t + LAT,     1, 0, 1, 0, 0);
    expect_at(t + LAT + 1, 1, 0, 0, 0, 0);
    wait_neg(10);
    t = edge_n; Run = 1'b1;
    expect_at(t + LAT, 0, 0, 0, 0, 0);
    wait_neg(8);

    // One-cycle glitches: no output may change.
    Run = 1'b0; wait_neg(1); Run = 1'b1; wait_neg(6);
    Continue = 1'b0; wait_neg(1); Continue = 1'b1; wait_neg(6);

    // Both buttons together: Soft_reset, no pulses.
    t = edge_n; Run = 1'b0; Continue = 1'b0;
    expect_at(t + LAT, 1, 1, 0, 0, 1);
    wait_neg(10);
    t = edge_n; Continue = 1'b1;
    expect_at(t + LAT, 1, 0, 0, 0, 0);
    wait_neg(8);
    t = edge_n; Run = 1'b1;
    expect_at(t + LAT, 0, 0, 0, 0, 0);
    wait_neg(8);

    // Switch synchronizer.
    SW = 10'h000; wait_neg(20);
    for (int i = 0; i < 3; i++) begin
      t = edge_n; SW = sw_vals[i]; exp_sw = sw_vals[i];
      expect_at(t + 2, 0, 0, 0, 0, 0);
      wait_neg(20);
    end

    // Back-to-back Continue presses.
    for (int i = 0; i < 3; i++) begin
      t = edge_n; Continue = 1'b0;
      expect_at(t + LAT,     0, 1, 0, 1, 0);
      expect_at(t + LAT + 1, 0, 1, 0, 0, 0);
      wait_neg(4);
      t = edge_n; Continue = 1'b1;
      expect_at(t + LAT, 0, 0, 0, 0, 0);
      wait_neg(4);
    end
    wait_neg(6);

    // Reset while Run is held and a Continue count is in flight.
    t = edge_n; Run = 1'b0;
    expect_at(t + LAT,     1, 0, 1, 0, 0);
    expect_at(t + LAT + 1, 1, 0, 0, 0, 0);
    wait_neg(8);
    Continue = 1'b0;
    wait_neg(3);
    r = edge_n;
    Reset_n = 1'b0; Continue = 1'b1;
    #1;
    checks++;
    if (outs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_immediate got=%h expected=%h", outs(), 15'd0);
    end
    exp_sw = 10'h000;
    expect_at(r + 1, 0, 0, 0, 0, 0);
    exp_sw = 10'h3FF;
    expect_at(r + 4, 0, 0, 0, 0, 0);
    expect_at(r + 6, 1, 0, 1, 0, 0);
    expect_at(r + 7, 1, 0, 0, 0, 0);
    wait_neg(2);
    Reset_n = 1'b1;
    wait_neg(8);
    t = edge_n; Run = 1'b1;
    expect_at(t + LAT, 0, 0, 0, 0, 0);
    wait_neg(8);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
